csa41_pipe_stage: RTL and testbench

Registered operand/result stage wrapped around the 41-bit carry-select adder datapath. Accepts operand pairs over a valid/ready stream, buffers them in a 2-entry skid buffer, and drives the combinational adder. Captures sum and carry-out into an output register with its own valid/ready handshake. Supports an accumulate mode that replaces operand 1 with the last produced sum, so the combinational adder can run inside the synchronous arithmetic pipeline.

---
 rtl/csa_pkg.sv | 19 +
 rtl/csa_skid_buf.sv | 36 +++
 rtl/csa41_pipe_stage.sv | 60 ++++++
 tb/tb_csa41_pipe_stage.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// csa_pkg: shared width, skid entry type, op-mode enum and carry-select add helper.
package csa_pkg;
  localparam int CSA_WIDTH = 41;
  typedef enum logic {CSA_OP_ADD, CSA_OP_ACC} csa_op_e;
  typedef struct packed {
    logic [CSA_WIDTH-1:0] term1;
    logic [CSA_WIDTH-1:0] term2;
    csa_op_e              acc_mode;
  } csa_entry_t;
  // Low 20 bits ripple; upper 21 bits computed for both carries and selected.
  function automatic logic [CSA_WIDTH:0] csa_add(input logic [CSA_WIDTH-1:0] a, input logic [CSA_WIDTH-1:0] b);
    logic [20:0] lo;
    logic [21:0] h0, h1;
    lo = {1'b0, a[19:0]} + {1'b0, b[19:0]};
    h0 = {1'b0, a[40:20]} + {1'b0, b[40:20]};
    h1 = h0 + 22'd1;
    return {lo[20] ? h1 : h0, lo[19:0]};
  endfunction
endpackage

// File: rtl/csa_skid_buf.sv
// csa_skid_buf: 2-entry FIFO skid buffer; ready comes from registered occupancy only.
module csa_skid_buf #(
  parameter type T = logic,
  parameter int DEPTH = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_push,
  input  T     i_data,
  output logic o_ready,
  input  logic i_pop,
  output T     o_data,
  output logic o_empty
);
  T r_mem [2];
  logic r_wr, r_rd;
  logic [1:0] r_cnt;
  logic w_push, w_pop;
  assign o_ready = r_cnt != 2'(DEPTH);
  assign o_empty = r_cnt == 2'd0;
  assign o_data  = r_mem[r_rd];
  assign w_push  = i_push && o_ready;
  assign w_pop   = i_pop && !o_empty;
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wr] <= i_data;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wr  <= 1'b0;
      r_rd  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) r_wr <= !r_wr;
      if (w_pop) r_rd <= !r_rd;
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
    end
endmodule

// File: rtl/csa41_pipe_stage.sv
// csa41_pipe_stage: skid-buffered operand stage, carry-select add, registered result with accumulate mode.
// Define CSA41_OVF_STICKY_EN to build the sticky carry-out flag; otherwise o_ovf_sticky is tied low.
module csa41_pipe_stage import csa_pkg::*; #(
  parameter int WIDTH = CSA_WIDTH,
  parameter int SKID_DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add_term1,
  input  logic [WIDTH-1:0] i_add_term2,
  input  logic             i_acc_mode,
  input  logic             i_clear,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf_sticky
);
  csa_entry_t w_in, w_head;
  logic w_empty, w_xfer;
  logic [WIDTH-1:0] w_a, r_acc;
  logic [WIDTH:0] w_res;
  assign w_in = '{term1: i_add_term1, term2: i_add_term2, acc_mode: i_acc_mode ? CSA_OP_ACC : CSA_OP_ADD};
  csa_skid_buf #(.T(csa_entry_t), .DEPTH(SKID_DEPTH)) u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_valid),
    .i_data  (w_in),
    .o_ready (o_ready),
    .i_pop   (w_xfer),
    .o_data  (w_head),
    .o_empty (w_empty)
  );
  assign w_xfer = !w_empty && (!o_valid || i_ready);
  // A clear in the same cycle zeroes the accumulator operand for this op
  assign w_a   = (w_head.acc_mode == CSA_OP_ACC) ? (i_clear ? '0 : r_acc) : w_head.term1;
  assign w_res = csa_add(w_a, w_head.term2);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_sum   <= '0;
      o_cout  <= 1'b0;
      r_acc   <= '0;
    end else begin
      if (w_xfer) {o_cout, o_sum} <= w_res;
      o_valid <= w_xfer || (o_valid && !i_ready);
      r_acc   <= w_xfer ? w_res[WIDTH-1:0] : i_clear ? '0 : r_acc;
    end
`ifdef CSA41_OVF_STICKY_EN
  logic r_sticky;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_sticky <= 1'b0;
    else r_sticky <= (r_sticky && !i_clear) || (w_xfer && w_res[WIDTH]);
  assign o_ovf_sticky = r_sticky;
`else
  assign o_ovf_sticky = 1'b0;
`endif
endmodule

// File: tb/tb_csa41_pipe_stage.sv
// tb_csa41_pipe_stage: directed scoreboard bench for csa41_pipe_stage.
module tb_csa41_pipe_stage;
  localparam int W = 41;
`ifdef CSA41_OVF_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif
  typedef struct packed {logic [W-1:0] sum; logic cout; logic stk;} exp_t;
  logic i_clk = 1'b0, i_rst_n = 1'b0, i_valid = 1'b0, i_acc_mode = 1'b0, i_clear = 1'b0, i_ready = 1'b1;
  logic [W-1:0] i_add_term1 = '0, i_add_term2 = '0;
  logic o_ready, o_valid, o_cout, o_ovf_sticky;
  logic [W-1:0] o_sum;
  exp_t sb[$];
  logic [W-1:0] m_acc = '0;
  logic m_stk = 1'b0;
  int n_chk = 0, n_fail = 0;
  always #5 i_clk = ~i_clk;
  csa41_pipe_stage dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_add_term1(i_add_term1), .i_add_term2(i_add_term2), .i_acc_mode(i_acc_mode),
    .i_clear(i_clear), .o_valid(o_valid), .i_ready(i_ready), .o_sum(o_sum),
    .o_cout(o_cout), .o_ovf_sticky(o_ovf_sticky)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic mclear();
    m_acc = '0;
    m_stk = 1'b0;
  endtask
  // Compare a handshaken result, model an accepted push, then advance one cycle.
  task automatic tick();
    exp_t e;
    logic [W:0] r;
    if (o_valid && i_ready) begin
      if (sb.size() == 0) chk("spurious_result", o_valid, 0);
      else begin
        e = sb.pop_front();
        chk("sum", o_sum, e.sum);
        chk("cout", o_cout, e.cout);
        chk("sticky", o_ovf_sticky, e.stk);
      end
    end
    if (i_valid && o_ready) begin
      r = {1'b0, (i_acc_mode ? m_acc : i_add_term1)} + {1'b0, i_add_term2};
      m_acc = r[W-1:0];
      m_stk = m_stk | r[W];
      sb.push_back('{sum: r[W-1:0], cout: r[W], stk: STK & m_stk});
    end
    @(posedge i_clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic acc, input logic [W-1:0] a, input logic [W-1:0] b);
    i_valid = v;
    i_acc_mode = acc;
    i_add_term1 = a;
    i_add_term2 = b;
  endtask
  task automatic drain(input int n);
    drive(0, 0, '0, '0);
    for (int i = 0; i < n; i++) tick();
  endtask
  logic [W-1:0] bp_a [4] = '{41'd10, 41'd30, 41'h1FFFFFFFFFF, 41'd7};
  logic [W-1:0] bp_b [4] = '{41'd20, 41'd40, 41'd2, 41'd8};
  logic [W-1:0] held;
  int k;
  initial begin
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_sum", o_sum, 0);
    chk("rst_cout", o_cout, 0);
    chk("rst_sticky", o_ovf_sticky, 0);
    chk("rst_ready", o_ready, 1);
    i_rst_n = 1'b1;
    tick();
    // single op and latency
    drive(1, 0, 41'h5, 41'hA);
    tick();
    drive(0, 0, '0, '0);
    chk("lat_t1_valid", o_valid, 0);
    tick();
    chk("lat_t2_valid", o_valid, 1);
    chk("lat_t2_sum", o_sum, 41'hF);
    tick();
    // overflow wrap and sticky persistence
    drive(1, 0, 41'h1FFFFFFFFFF, 41'h1);
    tick();
    drive(1, 0, 41'h1, 41'h1);
    tick();
    drain(3);
    // accumulate chain after clear
    i_clear = 1'b1;
    mclear();
    tick();
    i_clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 41'($urandom), 41'd3);
      tick();
    end
    drive(0, 0, '0, '0);
    chk("chain_valid_a", o_valid, 1);
    tick();
    chk("chain_valid_b", o_valid, 1);
    drain(2);
    // backpressure
    i_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1, 0, bp_a[k], bp_b[k]);
      if (o_ready) k++;
      if (c == 2) held = o_sum;
      if (c >= 3) begin
        chk("bp_ready_low", o_ready, 0);
        chk("bp_sum_hold", o_sum, held);
        chk("bp_valid_hold", o_valid, 1);
      end
      tick();
    end
    chk("bp_accepted", k, 3);
    i_ready = 1'b1;
    chk("bp_release_ready_same", o_ready, 0);
    tick();
    chk("bp_release_ready_next", o_ready, 1);
    for (int c = 0; c < 10; c++) begin
      if (k < 4) begin
        drive(1, 0, bp_a[k], bp_b[k]);
        if (o_ready) k++;
      end else drive(0, 0, '0, '0);
      tick();
    end
    chk("bp_all_accepted", k, 4);
    chk("bp_sb_empty", sb.size(), 0);
    // clear coinciding with an accumulate transfer
    i_clear = 1'b1;
    mclear();
    tick();
    i_clear = 1'b0;
    drive(1, 0, 41'd60, 41'd40);
    tick();
    drain(3);
    chk("acc100_sum", o_sum, 100);
    mclear();
    drive(1, 1, '0, 41'd7);
    tick();
    drive(0, 0, '0, '0);
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    chk("clr_xfer_sum", o_sum, 7);
    drive(1, 1, '0, 41'd1);
    tick();
    drain(3);
    chk("clr_acc_followup", o_sum, 8);
    // asynchronous reset with a full pipeline
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 41'(i + 1), 41'd100);
      tick();
    end
    drive(0, 0, '0, '0);
    chk("pre_rst_ready", o_ready, 0);
    chk("pre_rst_valid", o_valid, 1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_sum", o_sum, 0);
    chk("arst_cout", o_cout, 0);
    chk("arst_sticky", o_ovf_sticky, 0);
    chk("arst_ready", o_ready, 1);
    sb.delete();
    mclear();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    drain(4);
    drive(1, 1, 41'd99, 41'd5);
    tick();
    drain(3);
    chk("post_rst_acc", o_sum, 5);
    chk("final_sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
